// File: rtl/restoring_div_ctrl_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package restoring_div_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_DW = 4;
  localparam int unsigned DIV_VW = 2;

  // Iteration counter width; floored at 1 so DW=1 still gets a real register.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/restoring_div_ctrl_trial_sub.sv
// Combinational trial subtractor: diff = a - b, borrow set when b > a.
module trial_sub
  import restoring_div_ctrl_pkg::*;
#(
  parameter int unsigned W = DIV_VW + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] full;

  assign full   = {1'b0, a} - {1'b0, b};
  assign diff   = full[W-1:0];
  assign borrow = full[W];

endmodule

// File: rtl/restoring_div_ctrl.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional DIV_ZERO_FAST_EN: divisor 0 bypasses the loop and raises div_zero.
module restoring_div_ctrl
  import restoring_div_ctrl_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy
`ifdef DIV_ZERO_FAST_EN
  ,
  output logic          div_zero
`endif
);

  localparam int unsigned CW = clog2(DW);

  div_state_e    state_q;
  logic [DW-1:0] q_q;
  logic [VW:0]   r_q;
  logic [VW-1:0] dv_q;
  logic [CW-1:0] cnt_q;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          borrow;
  logic          unused_r_msb;

  // Shift the next dividend bit into the partial remainder before the trial.
  assign trial        = {r_q[VW-1:0], q_q[DW-1]};
  assign unused_r_msb = r_q[VW];

  trial_sub #(
    .W(VW + 1)
  ) u_trial_sub (
    .a     (trial),
    .b     ({1'b0, dv_q}),
    .diff  (diff),
    .borrow(borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      r_q       <= '0;
      dv_q      <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            q_q      <= dividend;
            r_q      <= '0;
            dv_q     <= divisor;
            cnt_q    <= '0;
            in_ready <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
              q_q       <= '1;
              r_q       <= {1'b0, dividend[VW-1:0]};
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              div_zero <= 1'b0;
              busy     <= 1'b1;
              state_q  <= S_RUN;
            end
`else
            busy    <= 1'b1;
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_q   <= borrow ? trial : diff;
          q_q   <= (q_q << 1) | DW'(!borrow);
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
            div_zero  <= 1'b0;
`endif
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q[VW-1:0];

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Scoreboard bench for restoring_div_ctrl; honours DIV_ZERO_FAST_EN when defined.
module tb_restoring_div_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned VW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
`ifdef DIV_ZERO_FAST_EN
  logic          div_zero;
`endif

  typedef struct {
    int            a;
    int            b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_issued = 0;
  int   n_done = 0;

  restoring_div_ctrl #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy)
`ifdef DIV_ZERO_FAST_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones and dividend mod 2^VW.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = VW'(a % (1 << VW));
`ifdef DIV_ZERO_FAST_EN
      e.dz  = 1'b1;
      e.lat = 0;
`else
      e.dz  = 1'b0;
      e.lat = DW;
`endif
    end else begin
      e.q   = DW'(a / b);
      e.r   = VW'(a % b);
      e.dz  = 1'b0;
      e.lat = DW;
    end
    return e;
  endfunction

  // Present operands and return just after the accepting edge.
  task automatic issue(input int a, input int b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(b);
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq($sformatf("accept %0d/%0d", a, b), 32'(in_ready), 32'd1);
    sb.push_back(model(a, b));
    n_issued++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Drain one result; hold forces that many stalled cycles once out_valid is up.
  task automatic collect(input int stall_pct, input int hold);
    int    cyc;
    bit    seen;
    bit    done;
    exp_t  e;
    string t;
    cyc  = 0;
    seen = 1'b0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      if (out_valid) begin
        check_eq("result_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) begin
          done = 1'b1;
        end else begin
          e = sb[0];
          t = $sformatf("%0d/%0d", e.a, e.b);
          if (!seen) begin
            check_eq({"latency ", t}, 32'(cyc), 32'(e.lat));
            seen = 1'b1;
          end
          check_eq({"quotient ", t}, 32'(quotient), 32'(e.q));
          check_eq({"remainder ", t}, 32'(remainder), 32'(e.r));
`ifdef DIV_ZERO_FAST_EN
          check_eq({"div_zero ", t}, 32'(div_zero), 32'(e.dz));
`endif
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
            check_eq({"in_ready_hold ", t}, 32'(in_ready), 32'd0);
          end else begin
            out_ready = ($urandom_range(99) >= 32'(stall_pct));
          end
          if (out_ready) begin
            void'(sb.pop_front());
            n_done++;
            done = 1'b1;
          end
        end
      end else begin
        out_ready = ($urandom_range(99) >= 32'(stall_pct));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("collect_done", 32'(done), 32'd1);
    out_ready = 1'b0;
    check_eq("in_ready_after", 32'(in_ready), 32'd1);
    check_eq("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst quotient", 32'(quotient), 32'd0);
    check_eq("rst remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;

    issue(13, 3);
    check_eq("run busy", 32'(busy), 32'd1);
    check_eq("run in_ready", 32'(in_ready), 32'd0);
    collect(0, 0);
    issue(15, 1);
    collect(0, 0);
    issue(2, 3);
    collect(0, 0);
    issue(9, 0);
    collect(0, 0);

    // Second op is presented during the stall and must wait its turn.
    issue(10, 3);
    in_valid = 1'b1;
    dividend = DW'(7);
    divisor  = VW'(2);
    collect(0, 5);
    issue(7, 2);
    collect(0, 0);

    // Load 14/3, reset lands on the second RUN edge.
    in_valid = 1'b1;
    dividend = DW'(14);
    divisor  = VW'(3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("midrst in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst quotient", 32'(quotient), 32'd0);
    issue(14, 3);
    collect(0, 0);

    for (int a = 0; a < (1 << DW); a++) begin
      for (int b = 0; b < (1 << VW); b++) begin
        issue(a, b);
        collect(30, 0);
      end
    end

    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    check_eq("results_count", 32'(n_done), 32'(n_issued));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
